// File: rtl/connect_fifo_sv.sv
// connect_fifo_sv: elastic in-order connect that buffers up to DEPTH words
// between a producer and a consumer using valid/ready handshakes.
//
// Ports:
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   flush      synchronous clear of all buffered words (beats push/pop)
//   d_in       write data
//   d_in_vld   write data valid
//   d_in_rdy   buffer can accept a word (registered state only)
//   d_out      oldest buffered word, 0 when empty
//   d_out_vld  d_out holds a valid word
//   d_out_rdy  consumer takes d_out this cycle
//   count      words currently buffered, 0..DEPTH
module connect_fifo_sv #(
  parameter  int DW    = 8,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic [DW-1:0] d_in,
  input  logic          d_in_vld,
  output logic          d_in_rdy,
  output logic [DW-1:0] d_out,
  output logic          d_out_vld,
  input  logic          d_out_rdy,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Ready/valid derive only from count, so d_out_rdy never reaches d_in_rdy
  // combinationally; a full buffer refuses pushes even while it is popped.
  assign d_in_rdy  = (count != FULL);
  assign d_out_vld = (count != '0);
  assign push      = d_in_vld && d_in_rdy;
  assign pop       = d_out_vld && d_out_rdy;
  assign d_out     = d_out_vld ? mem[rd_ptr] : '0;

  // Storage has no reset; stale words are hidden by d_out_vld gating.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= d_in;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_connect_fifo_sv.sv
module tb_connect_fifo_sv;

  logic       clk = 1'b0;
  logic       resetn;
  logic       flush;
  logic [7:0] d_in;
  logic       d_in_vld;
  logic       d_in_rdy;
  logic [7:0] d_out;
  logic       d_out_vld;
  logic       d_out_rdy;
  logic [2:0] count;

  int tests  = 0;
  int failed = 0;

  logic [7:0] sb[$];

  connect_fifo_sv #(.DW(8), .DEPTH(4)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .d_in      (d_in),
    .d_in_vld  (d_in_vld),
    .d_in_rdy  (d_in_rdy),
    .d_out     (d_out),
    .d_out_vld (d_out_vld),
    .d_out_rdy (d_out_rdy),
    .count     (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       f;
    logic       v;
    logic [7:0] d;
    logic       r;
    int         e_count;
    logic       e_irdy;
    logic       e_ovld;
    logic [7:0] e_dout;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard check of the current outputs against the reference queue.
  task automatic sb_check();
    logic [7:0] exp_d;
    exp_d = (sb.size() != 0) ? sb[0] : 8'h00;
    chk("sb_count", 32'(count), 32'(sb.size()));
    chk("sb_in_rdy", 32'(d_in_rdy), 32'(sb.size() != 4));
    chk("sb_out_vld", 32'(d_out_vld), 32'(sb.size() != 0));
    chk("sb_d_out", 32'(d_out), 32'(exp_d));
  endtask

  // One cycle: drive at negedge, check outputs, advance the model, clock.
  task automatic cyc(input logic f, input logic v, input logic [7:0] d, input logic r);
    logic m_push, m_pop;
    @(negedge clk);
    flush = f; d_in_vld = v; d_in = d; d_out_rdy = r;
    #1;
    sb_check();
    m_push = v && (sb.size() != 4);
    m_pop  = r && (sb.size() != 0);
    if (f) begin
      sb.delete();
    end else begin
      if (m_pop) void'(sb.pop_front());
      if (m_push) sb.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[17];

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1, 1'b1, 1'b1, 8'h11};
    vecs[1]  = '{1'b0, 1'b1, 8'h22, 1'b0, 2, 1'b1, 1'b1, 8'h11};
    vecs[2]  = '{1'b0, 1'b1, 8'h33, 1'b0, 3, 1'b1, 1'b1, 8'h11};
    vecs[3]  = '{1'b0, 1'b1, 8'h44, 1'b0, 4, 1'b0, 1'b1, 8'h11};
    vecs[4]  = '{1'b0, 1'b1, 8'h55, 1'b0, 4, 1'b0, 1'b1, 8'h11};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 3, 1'b1, 1'b1, 8'h22};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 2, 1'b1, 1'b1, 8'h33};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1, 1'b1, 1'b1, 8'h44};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 8'h00};
    vecs[9]  = '{1'b0, 1'b1, 8'hA1, 1'b0, 1, 1'b1, 1'b1, 8'hA1};
    vecs[10] = '{1'b0, 1'b1, 8'hA2, 1'b0, 2, 1'b1, 1'b1, 8'hA1};
    vecs[11] = '{1'b0, 1'b1, 8'hA3, 1'b0, 3, 1'b1, 1'b1, 8'hA1};
    vecs[12] = '{1'b0, 1'b1, 8'hA4, 1'b0, 4, 1'b0, 1'b1, 8'hA1};
    vecs[13] = '{1'b0, 1'b1, 8'h66, 1'b1, 3, 1'b1, 1'b1, 8'hA2};
    vecs[14] = '{1'b1, 1'b1, 8'h77, 1'b0, 0, 1'b1, 1'b0, 8'h00};
    vecs[15] = '{1'b0, 1'b1, 8'h88, 1'b0, 1, 1'b1, 1'b1, 8'h88};
    vecs[16] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 8'h00};

    resetn = 1'b0; flush = 1'b0; d_in = '0; d_in_vld = 1'b0; d_out_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_rdy", 32'(d_in_rdy), 32'd1);
    chk("rst_out_vld", 32'(d_out_vld), 32'd0);
    chk("rst_d_out", 32'(d_out), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("idle_count", 32'(count), 32'd0);
    chk("idle_out_vld", 32'(d_out_vld), 32'd0);

    // Fill/drain, full push+pop, flush with concurrent push.
    for (int i = 0; i < 17; i++) begin
      cyc(vecs[i].f, vecs[i].v, vecs[i].d, vecs[i].r);
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_count));
      chk($sformatf("vec%0d_in_rdy", i), 32'(d_in_rdy), 32'(vecs[i].e_irdy));
      chk($sformatf("vec%0d_out_vld", i), 32'(d_out_vld), 32'(vecs[i].e_ovld));
      chk($sformatf("vec%0d_d_out", i), 32'(d_out), 32'(vecs[i].e_dout));
    end

    // Streaming through several pointer wraps: count holds at 1.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 8'(i), 1'b1);
      chk($sformatf("stream%0d_count", i), 32'(count), 32'd1);
      chk($sformatf("stream%0d_d_out", i), 32'(d_out), 32'(i));
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("stream_end_vld", 32'(d_out_vld), 32'd0);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 200; i++) begin
      cyc(($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)),
          8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end
    cyc(1'b1, 1'b0, 8'h00, 1'b0);

    // Asynchronous reset between edges with two words buffered.
    cyc(1'b0, 1'b1, 8'hC1, 1'b0);
    cyc(1'b0, 1'b1, 8'hC2, 1'b0);
    chk("pre_arst_count", 32'(count), 32'd2);
    flush = 1'b0; d_in_vld = 1'b0; d_out_rdy = 1'b0;
    #1 resetn = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_out_vld", 32'(d_out_vld), 32'd0);
    chk("arst_in_rdy", 32'(d_in_rdy), 32'd1);
    chk("arst_d_out", 32'(d_out), 32'd0);
    resetn = 1'b1;
    sb.delete();
    cyc(1'b0, 1'b1, 8'hD5, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    sb_check();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
